ps2_rx_fifo: RTL

Parametrised PS/2 keyboard receiver that runs entirely in the system clock domain. It synchronises and de-glitches ps_clk/ps_data, frames and validates 11-bit PS/2 packets, and folds E0/F0 prefixes into single key events. Events are buffered in a FIFO with a valid/ready handshake. It sits between the PS/2 pins and the Battleship game/input logic, which pops key events at its own pace.

---
 rtl/ps2_rx_fifo.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchroniser, glitch filter, frame FSM, E0/F0 prefix folding, FWFT event FIFO.
// Optional build macro PS2_DEBUG_EN drives the registered dbg probe bus; otherwise dbg is tied low.
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | waiting for a start bit
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | waiting for the parity bit
// S_STOP   | waiting for the stop bit
// S_CHECK  | one cycle: validate frame, decode prefixes, push
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8,
  parameter int LVL_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps_clk,
  input  logic             ps_data,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow,
  output logic             frame_err,
  output logic [9:0]       dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
  localparam logic [TW-1:0]    TMO_L   = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_CHECK} state_t;

  logic [1:0]            clk_sync, data_sync;
  logic [FILTER_LEN-1:0] clk_sr, data_sr, clk_sr_nx, data_sr_nx;
  logic                  filt_clk, filt_data, filt_clk_d, fall;

  assign clk_sr_nx  = {clk_sr[FILTER_LEN-2:0], clk_sync[1]};
  assign data_sr_nx = {data_sr[FILTER_LEN-2:0], data_sync[1]};
  assign fall       = filt_clk_d & ~filt_clk;

  // Filtered levels only move once the whole window agrees; idle bus level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync   <= '1;
      data_sync  <= '1;
      clk_sr     <= '1;
      data_sr    <= '1;
      filt_clk   <= 1'b1;
      filt_data  <= 1'b1;
      filt_clk_d <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], ps_clk};
      data_sync  <= {data_sync[0], ps_data};
      clk_sr     <= clk_sr_nx;
      data_sr    <= data_sr_nx;
      filt_clk_d <= filt_clk;
      if (&clk_sr_nx)       filt_clk <= 1'b1;
      else if (~|clk_sr_nx) filt_clk <= 1'b0;
      if (&data_sr_nx)       filt_data <= 1'b1;
      else if (~|data_sr_nx) filt_data <= 1'b0;
    end
  end

  state_t         state, state_nx;
  logic [3:0]     bitcnt, bitcnt_nx;
  logic [7:0]     shreg, shreg_nx;
  logic           par_bit, par_nx, stop_bit, stop_nx;
  logic [TW-1:0]  tcnt, tcnt_nx;
  logic           ext, ext_nx, brk, brk_nx;
  logic           push, err_nx, timeout_hit, in_frame;
  logic [9:0]     push_data;

  assign push_data = {ext, brk, shreg};
  assign in_frame  = (state == S_DATA) || (state == S_PARITY) || (state == S_STOP);

  always_comb begin
    state_nx    = state;
    bitcnt_nx   = bitcnt;
    shreg_nx    = shreg;
    par_nx      = par_bit;
    stop_nx     = stop_bit;
    ext_nx      = ext;
    brk_nx      = brk;
    push        = 1'b0;
    err_nx      = 1'b0;
    tcnt_nx     = (in_frame && !fall) ? tcnt + TW'(1) : '0;
    timeout_hit = in_frame && !fall && (tcnt == TMO_L);

    case (state)
      S_IDLE: begin
        if (fall) begin
          if (!filt_data) begin
            state_nx  = S_DATA;
            bitcnt_nx = 4'd0;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (fall) begin
          shreg_nx  = {filt_data, shreg[7:1]};
          bitcnt_nx = bitcnt + 4'd1;
          if (bitcnt == 4'd7) state_nx = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_nx   = filt_data;
          state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          stop_nx  = filt_data;
          state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        state_nx = S_IDLE;
        if ((^{par_bit, shreg}) && stop_bit) begin
          case (shreg)
            8'hE0: ext_nx = 1'b1;
            8'hF0: brk_nx = 1'b1;
            8'h00, 8'hFF: begin
              err_nx = 1'b1;
              ext_nx = 1'b0;
              brk_nx = 1'b0;
            end
            default: begin
              push   = 1'b1;
              ext_nx = 1'b0;
              brk_nx = 1'b0;
            end
          endcase
        end else begin
          err_nx = 1'b1;
          ext_nx = 1'b0;
          brk_nx = 1'b0;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if (timeout_hit) begin
      state_nx = S_IDLE;
      err_nx   = 1'b1;
      ext_nx   = 1'b0;
      brk_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      stop_bit  <= 1'b0;
      tcnt      <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      bitcnt    <= bitcnt_nx;
      shreg     <= shreg_nx;
      par_bit   <= par_nx;
      stop_bit  <= stop_nx;
      tcnt      <= tcnt_nx;
      ext       <= ext_nx;
      brk       <= brk_nx;
      frame_err <= err_nx;
    end
  end

  logic [9:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_nx;
  logic [LVL_W-1:0] lvl_after_pop, level_nx;
  logic             pop, full, push_ok, drop;
  logic [9:0]       head_nx;

  always_comb begin
    pop           = evt_valid & evt_ready;
    full          = (fifo_level == DEPTH_L);
    push_ok       = push & (~full | pop);
    drop          = push & ~push_ok;
    lvl_after_pop = pop ? fifo_level - LVL_W'(1) : fifo_level;
    level_nx      = push_ok ? lvl_after_pop + LVL_W'(1) : lvl_after_pop;
    rd_nx         = pop ? rd_ptr + AW'(1) : rd_ptr;
    // An event written into an otherwise empty FIFO becomes the head directly.
    head_nx       = (lvl_after_pop == '0) ? push_data : mem[rd_nx];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      evt_valid  <= 1'b0;
      evt_code   <= '0;
      evt_ext    <= 1'b0;
      evt_break  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_nx;
      fifo_level <= level_nx;
      evt_valid  <= (level_nx != '0);
      {evt_ext, evt_break, evt_code} <= head_nx;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef PS2_DEBUG_EN
  logic [9:0] dbg_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dbg_q <= '0;
    else     dbg_q <= {timeout_hit, bitcnt, state, filt_data, filt_clk};
  end
  assign dbg = dbg_q;
`else
  assign dbg = 10'b0;
`endif

endmodule
